// File: rtl/rotate_right_seq_op.sv
// Multi-cycle rotate-right unit: rotates a right by b[LOG2N-1:0], one bit position per clock.
// Valid/ready handshakes on both the operand side and the result side.
module rotate_right_seq_op #(
  parameter int N     = 8,
  parameter int LOG2N = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROTATE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]       state;
  logic [N-1:0]     data;
  logic [LOG2N-1:0] cnt;
  logic [LOG2N-1:0] amount;

  // Rotation is modulo N, so only the low LOG2N bits of b matter.
  assign amount = b[LOG2N-1:0];
  logic unused_b;
  assign unused_b = ^b[N-1:LOG2N];

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      data  <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            data  <= a;
            cnt   <= amount;
            state <= (amount == '0) ? S_DONE : S_ROTATE;
          end
        end
        S_ROTATE: begin
          data <= {data[0], data[N-1:1]};
          cnt  <= cnt - LOG2N'(1);
          // cnt is at least 1 here, so it reaches 0 exactly as we leave.
          if (cnt == LOG2N'(1)) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_ROTATE) || (state == S_DONE);
  assign out       = data;

endmodule
